a5_1_wrapper: RTL and testbench
===============================

# a5_1_wrapper

A5/1 stream-cipher keystream generator packaged as the user-project wrapper of the SoC harness. The host (management CPU) loads a 64-bit key and a 22-bit frame number over the Wishbone slave port, starts the engine, and reads keystream 32 bits at a time. Status is mirrored on two I/O pads and the logic analyzer. All outputs are gated by `active`.

## Interface
- `BASE_ADDR`, default 32'h3000_0000: Wishbone base address; registers decoded at `BASE_ADDR + {0x00..0x10}`.
- `MPRJ_IO_PADS`, default 38: I/O pad count, taken from the harness macro.

- `wb_clk_i` in 1: the single clock; all logic is on its rising edge.
- `wb_rst_i` in 1: reset, synchronous and active-high.
- `wbs_stb_i`, `wbs_cyc_i` in 1: Wishbone strobe and cycle.
- `wbs_we_i` in 1: write enable.
- `wbs_sel_i` in 4: byte enables for writes.
- `wbs_dat_i` in 32: write data.
- `wbs_adr_i` in 32: byte address.
- `wbs_ack_o` out 1: acknowledge.
- `wbs_dat_o` out 32: read data.
- `la_data_in` in 32: unused.
- `la_oen` in 32: unused.
- `la_data_out` out 32: current keystream word.
- `io_in` in MPRJ_IO_PADS: unused.
- `io_out` out MPRJ_IO_PADS: bit 8 is `valid`, bit 9 is `busy`, all other bits 0.
- `io_oeb` out MPRJ_IO_PADS: 0 on bits 8 and 9 when `active`, otherwise all 1.
- `active` in 1: project select. When low, `wbs_ack_o`, `wbs_dat_o`, `la_data_out` and `io_out` are forced to 0 and `io_oeb` to all 1. Internal state keeps running.

## Operation
- **Registers** (word offsets; `wbs_adr_i[1:0]` ignored; any other address acks with read data 0 and writes ignored):
  - 0x00 KEY_LO, R/W, key[31:0].
  - 0x04 KEY_HI, R/W, key[63:32].
  - 0x08 FRAME, R/W, bits [21:0]; upper bits read 0.
  - 0x0C CTRL/STATUS. Writing with bit0=1 starts the engine. Read returns {30'b0, busy, valid}.
  - 0x10 KEYSTREAM, read only. Returns the current word; a read while `valid` clears `valid` and starts generating the next word.
- **Byte enables:** `wbs_sel_i` applies to KEY/FRAME writes. CTRL acts if `sel[0]` is set.
- **LFSR R1** (19 bits): taps 18,17,16,13; clock bit 8.
- **LFSR R2** (22 bits): taps 21,20; clock bit 10.
- **LFSR R3** (23 bits): taps 22,21,20,7; clock bit 10.
- **Register shift:** shift left; the XOR of the taps enters bit 0.
- **Output bit:** R1[18]^R2[21]^R3[22].
- **FSM states:** IDLE → KEY(64) → FRAME(22) → MIX(100) → GEN(32) → READY.
  - Start (in any state) clears all LFSRs and enters KEY.
  - KEY/FRAME: each cycle, clock all three registers, then XOR key[i] / frame[i] into bit 0 of each. Bit order is i=0 first.
  - MIX: majority clocking; a register steps only if its clock bit equals the majority of the three clock bits. Output is discarded.
  - GEN: majority-clock, then take the output bit of the new state into word bit 0, shifting the word left. The first bit ends in bit 31.
  - After 32 bits: `valid`=1, state READY.
  - A KEYSTREAM read in READY goes to GEN, and the word register holds until the next word completes.
- **busy** = state ∈ {KEY, FRAME, MIX, GEN}.
- **Reset values:** all registers, key, frame, word and flags are 0; state IDLE; `wbs_ack_o`=0.

## Timing
- **Ack:** registered. `wbs_ack_o`=1 for exactly one cycle, the cycle after `stb&cyc` is sampled high with ack low. Back-to-back requests therefore ack every other cycle.
- **Read data:** valid in the ack cycle.
- **Write timing:** writes and the read side-effect take effect at the edge that raises ack.
- **Start latency:** start accepted at edge T → `busy` from T+1. The first `valid` appears 218 cycles later (64+22+100+32). Each subsequent word takes 32 cycles after the read.
- **Start while busy:** restarts from KEY with the current key and frame. `valid` is cleared.
- **Key/frame writes while busy:** take effect only at the next start.
- **Reset mid-operation:** returns to IDLE, all zero, on the next edge.

## Structure
- **Shared package `a5_1_pkg`:**
  - LFSR lengths, tap and clock-bit indices.
  - Phase counts 64/22/100/32.
  - Register offsets.
  - FSM state enum.
- **Sub-module `a5_1_core`:** LFSRs, FSM, word shift register. Ports: start, key, frame, next, word, busy, valid.
- **Wrapper:** Wishbone decode, ack and `active` gating.

## Test plan
- Reset, `active`=1 → all outputs 0, `io_oeb` only bits 8/9 low; CTRL/STATUS reads 0.
- Write KEY_LO=0x67452312, KEY_HI=0xEFCDAB89, FRAME=0x134, start → `busy` next cycle; `valid` after 218 cycles; KEYSTREAM reads 0x534EAA58, then 0x2FE8151A.
- Write KEY_LO with `sel`=4'b0001, data 0xFFFFFFFF after 0 → reads back 0x000000FF; unmapped address 0x20 acks and reads 0.
- Restart mid-MIX with the same key/frame → first word again 0x534EAA58, 218 cycles after the second start.
- `active`=0 during a read → no ack, `wbs_dat_o`=0, `io_oeb` all 1; raising `active` resumes normal acks.
- Assert `wb_rst_i` during GEN → next cycle `busy`=`valid`=0, KEY registers read 0.

Source files
------------

// File: rtl/a5_1_pkg.sv
// a5_1_pkg: shared constants, register map and FSM state type for the A5/1 keystream engine
package a5_1_pkg;
  localparam int R1_LEN = 19;
  localparam int R2_LEN = 22;
  localparam int R3_LEN = 23;
  localparam int R1_CLK = 8;
  localparam int R2_CLK = 10;
  localparam int R3_CLK = 10;
  localparam logic [R1_LEN-1:0] R1_TAPS = 19'h7_2000;
  localparam logic [R2_LEN-1:0] R2_TAPS = 22'h30_0000;
  localparam logic [R3_LEN-1:0] R3_TAPS = 23'h70_0080;
  localparam int KEY_CYC = 64;
  localparam int FRAME_CYC = 22;
  localparam int MIX_CYC = 100;
  localparam int GEN_CYC = 32;
  localparam logic [2:0] OFF_KEY_LO = 3'd0;
  localparam logic [2:0] OFF_KEY_HI = 3'd1;
  localparam logic [2:0] OFF_FRAME = 3'd2;
  localparam logic [2:0] OFF_CTRL = 3'd3;
  localparam logic [2:0] OFF_STREAM = 3'd4;
  typedef enum logic [2:0] {S_IDLE, S_KEY, S_FRAME, S_MIX, S_GEN, S_READY} state_t;
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din, input logic [3:0] sel);
    for (int i = 0; i < 4; i++) merge[8*i+:8] = sel[i] ? din[8*i+:8] : old[8*i+:8];
  endfunction
endpackage

// File: rtl/a5_1_wrapper_if.sv
// a5_1_wrapper_if: Wishbone slave bundle between the management CPU and the keystream engine
interface a5_1_wrapper_if;
  logic wbs_stb_i;
  logic wbs_cyc_i;
  logic wbs_we_i;
  logic [3:0] wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic wbs_ack_o;
  logic [31:0] wbs_dat_o;
  modport master(output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i, input wbs_ack_o, wbs_dat_o);
  modport slave(input wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i, output wbs_ack_o, wbs_dat_o);
endinterface

// File: rtl/a5_1_core.sv
// a5_1_core: three A5/1 LFSRs with key/frame loading, mixing and 32-bit keystream word generation
module a5_1_core
  import a5_1_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        next,
  input  logic [63:0] key,
  input  logic [21:0] frame,
  output logic [31:0] word,
  output logic        busy,
  output logic        valid
);
  state_t state, state_n;
  logic [6:0] cnt, cnt_n, len;
  logic [R1_LEN-1:0] r1, r1_n, s1, m1;
  logic [R2_LEN-1:0] r2, r2_n, s2, m2;
  logic [R3_LEN-1:0] r3, r3_n, s3, m3;
  logic [63:0] src;
  logic [31:0] sh, sh_n, word_n;
  logic in_bit, maj, ob, last, valid_n;
  assign s1 = {r1[R1_LEN-2:0], ^(r1 & R1_TAPS)};
  assign s2 = {r2[R2_LEN-2:0], ^(r2 & R2_TAPS)};
  assign s3 = {r3[R3_LEN-2:0], ^(r3 & R3_TAPS)};
  assign maj = (r1[R1_CLK] & r2[R2_CLK]) | (r1[R1_CLK] & r3[R3_CLK]) | (r2[R2_CLK] & r3[R3_CLK]);
  assign m1 = r1[R1_CLK] == maj ? s1 : r1;
  assign m2 = r2[R2_CLK] == maj ? s2 : r2;
  assign m3 = r3[R3_CLK] == maj ? s3 : r3;
  assign ob = m1[R1_LEN-1] ^ m2[R2_LEN-1] ^ m3[R3_LEN-1];
  assign src = state == S_KEY ? key : {42'b0, frame};
  assign in_bit = src[cnt[5:0]];
  assign len = state == S_KEY ? 7'(KEY_CYC) : state == S_FRAME ? 7'(FRAME_CYC) : state == S_MIX ? 7'(MIX_CYC) : 7'(GEN_CYC);
  assign last = cnt == len - 7'd1;
  assign busy = state == S_KEY || state == S_FRAME || state == S_MIX || state == S_GEN;
  always_comb begin
    state_n = state;
    cnt_n = busy ? (last ? 7'd0 : cnt + 7'd1) : cnt;
    r1_n = r1;
    r2_n = r2;
    r3_n = r3;
    sh_n = sh;
    word_n = word;
    valid_n = valid;
    case (state)
      S_KEY, S_FRAME: begin
        r1_n = s1 ^ R1_LEN'(in_bit);
        r2_n = s2 ^ R2_LEN'(in_bit);
        r3_n = s3 ^ R3_LEN'(in_bit);
        state_n = !last ? state : state == S_KEY ? S_FRAME : S_MIX;
      end
      S_MIX: begin
        {r1_n, r2_n, r3_n} = {m1, m2, m3};
        state_n = last ? S_GEN : state;
      end
      S_GEN: begin
        {r1_n, r2_n, r3_n} = {m1, m2, m3};
        sh_n = {sh[30:0], ob};
        word_n = last ? sh_n : word;
        valid_n = last;
        state_n = last ? S_READY : state;
      end
      S_READY: begin
        state_n = next ? S_GEN : state;
        valid_n = !next;
      end
      default: ;
    endcase
    if (start) begin
      {r1_n, r2_n, r3_n} = '0;
      cnt_n = '0;
      valid_n = 1'b0;
      state_n = S_KEY;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      {r1, r2, r3} <= '0;
      sh <= '0;
      word <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      {r1, r2, r3} <= {r1_n, r2_n, r3_n};
      sh <= sh_n;
      word <= word_n;
      valid <= valid_n;
    end
  end
endmodule

// File: rtl/a5_1_wrapper.sv
// a5_1_wrapper: user-project wrapper exposing the A5/1 engine over Wishbone, pads and logic analyzer
module a5_1_wrapper
  import a5_1_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int MPRJ_IO_PADS = 38
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  a5_1_wrapper_if.slave           wb,
  input  logic [31:0]             la_data_in,
  input  logic [31:0]             la_oen,
  output logic [31:0]             la_data_out,
  input  logic [MPRJ_IO_PADS-1:0] io_in,
  output logic [MPRJ_IO_PADS-1:0] io_out,
  output logic [MPRJ_IO_PADS-1:0] io_oeb,
  input  logic                    active
);
  logic ack, req, hit, wr, start, next, busy, valid;
  logic [2:0] off;
  logic [31:0] dat, rdata, word;
  logic [63:0] key;
  logic [21:0] frame;
  logic unused_ok;
  assign unused_ok = ^{la_data_in, la_oen, io_in, wb.wbs_adr_i[1:0]};
  assign req = wb.wbs_stb_i & wb.wbs_cyc_i & ~ack;
  assign off = wb.wbs_adr_i[4:2];
  assign hit = wb.wbs_adr_i[31:5] == BASE_ADDR[31:5] && off <= OFF_STREAM;
  assign wr = req & wb.wbs_we_i & hit;
  assign start = wr && off == OFF_CTRL && wb.wbs_sel_i[0] && wb.wbs_dat_i[0];
  assign next = req && !wb.wbs_we_i && hit && off == OFF_STREAM && valid;
  assign rdata = !hit ? '0 : off == OFF_KEY_LO ? key[31:0] : off == OFF_KEY_HI ? key[63:32] :
                 off == OFF_FRAME ? {10'b0, frame} : off == OFF_CTRL ? {30'b0, busy, valid} : word;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack <= 1'b0;
      dat <= '0;
      key <= '0;
      frame <= '0;
    end else begin
      ack <= req;
      dat <= req ? rdata : '0;
      if (wr && off == OFF_KEY_LO) key[31:0] <= merge(key[31:0], wb.wbs_dat_i, wb.wbs_sel_i);
      if (wr && off == OFF_KEY_HI) key[63:32] <= merge(key[63:32], wb.wbs_dat_i, wb.wbs_sel_i);
      if (wr && off == OFF_FRAME) frame <= 22'(merge({10'b0, frame}, wb.wbs_dat_i, wb.wbs_sel_i));
    end
  end
  a5_1_core u_core (
    .clk(wb_clk_i),
    .rst(wb_rst_i),
    .start(start),
    .next(next),
    .key(key),
    .frame(frame),
    .word(word),
    .busy(busy),
    .valid(valid)
  );
  // The harness sees nothing from an unselected project; internal state is untouched.
  assign wb.wbs_ack_o = active & ack;
  assign wb.wbs_dat_o = active ? dat : '0;
  assign la_data_out = active ? word : '0;
  assign io_out = active ? MPRJ_IO_PADS'({busy, valid}) << 8 : '0;
  assign io_oeb = active ? ~(MPRJ_IO_PADS'(2'b11) << 8) : '1;
endmodule

// File: tb/tb_a5_1_wrapper.sv
// tb_a5_1_wrapper: directed checks of register access, keystream vectors, restart, gating and reset
module tb_a5_1_wrapper;
  localparam int P = 38;
  localparam logic [31:0] B = 32'h3000_0000;
  localparam logic [P-1:0] OEB_ON = ~(P'(2'b11) << 8);
  logic clk = 1'b0, rst = 1'b1, active = 1'b1;
  logic [31:0] la_data_in = '0, la_oen = '0, la_data_out;
  logic [P-1:0] io_in = '0, io_out, io_oeb;
  int n_cmp = 0, n_bad = 0;
  a5_1_wrapper_if wb();
  a5_1_wrapper #(.BASE_ADDR(B), .MPRJ_IO_PADS(P)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb(wb), .la_data_in(la_data_in), .la_oen(la_oen),
    .la_data_out(la_data_out), .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .active(active)
  );
  always #5 clk = ~clk;

  task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] wd, input logic [3:0] sel, output logic [31:0] rd);
    logic got = 1'b0;
    @(negedge clk);
    {wb.wbs_stb_i, wb.wbs_cyc_i, wb.wbs_we_i} = {2'b11, we};
    {wb.wbs_adr_i, wb.wbs_dat_i, wb.wbs_sel_i} = {adr, wd, sel};
    rd = 'x;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (wb.wbs_ack_o) begin got = 1'b1; rd = wb.wbs_dat_o; end
    end
    {wb.wbs_stb_i, wb.wbs_cyc_i, wb.wbs_we_i} = 3'b000;
    n_cmp++; if (!got) begin n_bad++; $display("FAIL bus_ack adr=%h: no ack seen, required ack within 8 cycles", adr); end
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] d, input logic [3:0] sel = 4'hF);
    logic [31:0] x;
    bus(1'b1, adr, d, sel, x);
  endtask

  task automatic rd(input logic [31:0] adr, output logic [31:0] d);
    bus(1'b0, adr, 32'h0, 4'hF, d);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    n_cmp++; if (wb.wbs_ack_o !== 1'b0) begin n_bad++; $display("FAIL reset_ack got %b want 0", wb.wbs_ack_o); end
    n_cmp++; if (wb.wbs_dat_o !== 32'h0) begin n_bad++; $display("FAIL reset_dat got %h want 0", wb.wbs_dat_o); end
    n_cmp++; if (la_data_out !== 32'h0) begin n_bad++; $display("FAIL reset_la got %h want 0", la_data_out); end
    n_cmp++; if (io_out !== '0) begin n_bad++; $display("FAIL reset_io_out got %h want 0", io_out); end
    n_cmp++; if (io_oeb !== OEB_ON) begin n_bad++; $display("FAIL reset_io_oeb got %h want %h", io_oeb, OEB_ON); end
    rd(B + 32'h0C, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_status got %h want 0", d); end
  endtask

  task automatic wait_first_word(input string tag);
    repeat (217) @(posedge clk); #1;
    n_cmp++; if (io_out[8] !== 1'b0) begin n_bad++; $display("FAIL %s_valid_early got %b want 0 at 217", tag, io_out[8]); end
    @(posedge clk); #1;
    n_cmp++; if (io_out[8] !== 1'b1) begin n_bad++; $display("FAIL %s_valid got %b want 1 at 218", tag, io_out[8]); end
    n_cmp++; if (io_out[9] !== 1'b0) begin n_bad++; $display("FAIL %s_busy_ready got %b want 0", tag, io_out[9]); end
  endtask

  task automatic test_keystream;
    logic [31:0] d;
    wr(B + 32'h00, 32'h6745_2312);
    wr(B + 32'h04, 32'hEFCD_AB89);
    wr(B + 32'h08, 32'h0000_0134);
    rd(B + 32'h08, d);
    n_cmp++; if (d !== 32'h134) begin n_bad++; $display("FAIL frame_rb got %h want 00000134", d); end
    wr(B + 32'h0C, 32'h1);
    n_cmp++; if (io_out[9:8] !== 2'b10) begin n_bad++; $display("FAIL start_busy got %b want 10", io_out[9:8]); end
    wait_first_word("ks");
    n_cmp++; if (la_data_out !== 32'h534E_AA58) begin n_bad++; $display("FAIL ks_la got %h want 534eaa58", la_data_out); end
    rd(B + 32'h10, d);
    n_cmp++; if (d !== 32'h534E_AA58) begin n_bad++; $display("FAIL ks_word1 got %h want 534eaa58", d); end
    @(posedge clk); #1;
    n_cmp++; if (wb.wbs_ack_o !== 1'b0) begin n_bad++; $display("FAIL ack_one_cycle got %b want 0", wb.wbs_ack_o); end
    repeat (30) @(posedge clk); #1;
    n_cmp++; if (io_out[9:8] !== 2'b10) begin n_bad++; $display("FAIL ks_gen_flags got %b want 10", io_out[9:8]); end
    n_cmp++; if (la_data_out !== 32'h534E_AA58) begin n_bad++; $display("FAIL ks_hold got %h want 534eaa58", la_data_out); end
    @(posedge clk); #1;
    n_cmp++; if (io_out[8] !== 1'b1) begin n_bad++; $display("FAIL ks_valid2 got %b want 1 at 32", io_out[8]); end
    rd(B + 32'h10, d);
    n_cmp++; if (d !== 32'h2FE8_151A) begin n_bad++; $display("FAIL ks_word2 got %h want 2fe8151a", d); end
  endtask

  task automatic test_restart;
    logic [31:0] d;
    wr(B + 32'h0C, 32'h1);
    repeat (100) @(posedge clk); #1;
    n_cmp++; if (io_out[9:8] !== 2'b10) begin n_bad++; $display("FAIL mix_flags got %b want 10", io_out[9:8]); end
    wr(B + 32'h0C, 32'h1);
    wait_first_word("restart");
    rd(B + 32'h10, d);
    n_cmp++; if (d !== 32'h534E_AA58) begin n_bad++; $display("FAIL restart_word got %h want 534eaa58", d); end
  endtask

  task automatic test_byte_enable;
    logic [31:0] d;
    wr(B + 32'h00, 32'h0);
    wr(B + 32'h00, 32'hFFFF_FFFF, 4'b0001);
    rd(B + 32'h00, d);
    n_cmp++; if (d !== 32'h0000_00FF) begin n_bad++; $display("FAIL sel_key_lo got %h want 000000ff", d); end
    wr(B + 32'h20, 32'hDEAD_BEEF);
    rd(B + 32'h20, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL unmapped got %h want 0", d); end
    rd(B + 32'h04, d);
    n_cmp++; if (d !== 32'hEFCD_AB89) begin n_bad++; $display("FAIL key_hi_keep got %h want efcdab89", d); end
  endtask

  task automatic test_active;
    logic [31:0] d;
    logic seen = 1'b0;
    @(negedge clk);
    active = 1'b0;
    #1;
    n_cmp++; if (io_oeb !== '1) begin n_bad++; $display("FAIL inactive_oeb got %h want all ones", io_oeb); end
    n_cmp++; if (io_out !== '0 || la_data_out !== 32'h0) begin n_bad++; $display("FAIL inactive_out io=%h la=%h want 0", io_out, la_data_out); end
    {wb.wbs_stb_i, wb.wbs_cyc_i, wb.wbs_we_i, wb.wbs_adr_i} = {3'b110, B + 32'h04};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (wb.wbs_ack_o !== 1'b0 || wb.wbs_dat_o !== 32'h0) seen = 1'b1;
    end
    n_cmp++; if (seen) begin n_bad++; $display("FAIL inactive_bus got ack/data activity, required none"); end
    {wb.wbs_stb_i, wb.wbs_cyc_i} = 2'b00;
    @(negedge clk);
    active = 1'b1;
    rd(B + 32'h04, d);
    n_cmp++; if (d !== 32'hEFCD_AB89) begin n_bad++; $display("FAIL reactive_rd got %h want efcdab89", d); end
  endtask

  task automatic test_reset_in_gen;
    logic [31:0] d;
    wr(B + 32'h0C, 32'h1);
    repeat (199) @(posedge clk); #1;
    n_cmp++; if (io_out[9] !== 1'b1) begin n_bad++; $display("FAIL gen_busy got %b want 1", io_out[9]); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (io_out[9:8] !== 2'b00) begin n_bad++; $display("FAIL rst_flags got %b want 00", io_out[9:8]); end
    n_cmp++; if (la_data_out !== 32'h0) begin n_bad++; $display("FAIL rst_word got %h want 0", la_data_out); end
    rst = 1'b0;
    rd(B + 32'h00, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL rst_key_lo got %h want 0", d); end
    rd(B + 32'h04, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL rst_key_hi got %h want 0", d); end
  endtask

  initial begin
    {wb.wbs_stb_i, wb.wbs_cyc_i, wb.wbs_we_i, wb.wbs_sel_i} = '0;
    {wb.wbs_adr_i, wb.wbs_dat_i} = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset;
    test_keystream;
    test_restart;
    test_byte_enable;
    test_active;
    test_reset_in_gen;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
